// File: rtl/scalar_pkg.sv
// scalar_pkg: shared ALU select encoding, default widths and bubble values for the scalar pipeline.
package scalar_pkg;
  localparam int N_DEF = 32;
  localparam int R_DEF = 4;
  localparam logic [2:0] SEL_ZERO = 3'd0;
  localparam logic [2:0] SEL_PASS = 3'd1;
  localparam logic [2:0] SEL_ADD = 3'd2;
  localparam logic [2:0] SEL_SUB = 3'd3;
  localparam logic [2:0] SEL_MUL = 3'd4;
  localparam logic [2:0] SEL_DIV = 3'd5;
  localparam logic BUBBLE_VALID = 1'b0;
  localparam logic [2:0] BUBBLE_SEL = SEL_ZERO;
  function automatic logic sel_reserved(input logic [2:0] sel);
    return sel > SEL_DIV;
  endfunction
endpackage

// File: rtl/scalar_forward_unit.sv
// scalar_forward_unit: resolves one source operand from EX/MEM, MEM/WB or the register file.
module scalar_forward_unit #(
  parameter int N = 32,
  parameter int R = 4
) (
  input  logic [R-1:0] addr,
  input  logic [N-1:0] rf_data,
  input  logic         exm_reg_write,
  input  logic [R-1:0] exm_rd_addr,
  input  logic [N-1:0] exm_data,
  input  logic         wb_reg_write,
  input  logic [R-1:0] wb_rd_addr,
  input  logic [N-1:0] wb_data,
  output logic [N-1:0] value
);
  always_comb
    value = (addr == '0) ? '0 :
            (exm_reg_write && exm_rd_addr == addr) ? exm_data :
            (wb_reg_write && wb_rd_addr == addr) ? wb_data : rf_data;
endmodule

// File: rtl/scalar_operand_stage.sv
// scalar_operand_stage: ID/EX register stage producing forwarded ALU operands and retire sideband.
module scalar_operand_stage
  import scalar_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int R = R_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         id_valid,
  input  logic [R-1:0] id_rs1_addr,
  input  logic [R-1:0] id_rs2_addr,
  input  logic [N-1:0] id_rs1_data,
  input  logic [N-1:0] id_rs2_data,
  input  logic [N-1:0] id_imm,
  input  logic         id_use_imm,
  input  logic [2:0]   id_sel,
  input  logic [R-1:0] id_rd_addr,
  input  logic         id_reg_write,
  input  logic         id_flag_write,
  input  logic         exm_reg_write,
  input  logic [R-1:0] exm_rd_addr,
  input  logic [N-1:0] exm_data,
  input  logic         wb_reg_write,
  input  logic [R-1:0] wb_rd_addr,
  input  logic [N-1:0] wb_data,
  input  logic         stall,
  input  logic         flush,
  output logic         ex_valid,
  output logic [N-1:0] ex_A,
  output logic [N-1:0] ex_B,
  output logic [2:0]   ex_sel,
  output logic [R-1:0] ex_rd_addr,
  output logic         ex_reg_write,
  output logic         ex_flag_write
);
  logic [N-1:0] rs1_val, rs2_val;
  logic retire;
  scalar_forward_unit #(.N(N), .R(R)) u_fwd_rs1 (
    .addr(id_rs1_addr), .rf_data(id_rs1_data),
    .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr), .exm_data(exm_data),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .value(rs1_val)
  );
  scalar_forward_unit #(.N(N), .R(R)) u_fwd_rs2 (
    .addr(id_rs2_addr), .rf_data(id_rs2_data),
    .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr), .exm_data(exm_data),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .value(rs2_val)
  );
  // reserved ops still flow to the ALU (which outputs zero) but must never retire
  assign retire = !sel_reserved(id_sel);
  always_ff @(posedge clk) begin
    if (rst || flush || (!stall && !id_valid)) begin
      ex_valid      <= BUBBLE_VALID;
      ex_A          <= '0;
      ex_B          <= '0;
      ex_sel        <= BUBBLE_SEL;
      ex_rd_addr    <= '0;
      ex_reg_write  <= 1'b0;
      ex_flag_write <= 1'b0;
    end else if (!stall) begin
      ex_valid      <= 1'b1;
      ex_A          <= rs1_val;
      ex_B          <= id_use_imm ? id_imm : rs2_val;
      ex_sel        <= id_sel;
      ex_rd_addr    <= id_rd_addr;
      ex_reg_write  <= id_reg_write && retire;
      ex_flag_write <= id_flag_write && retire;
    end
  end
endmodule
